audio_i2s_tx: RTL

Stereo I2S transmitter clocked by the 12.288 MHz audio PLL output. It derives BCLK and LRCLK, serialises accepted stereo samples to the codec DAC, and holds everything muted until the PLL `locked` indication has been stable for a qualification period. It sits directly downstream of the audio PLL and upstream of the codec's serial data input.

---
 rtl/audio_i2s_tx.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/audio_i2s_tx.sv
// Stereo I2S transmitter: derives BCLK/LRCLK from the audio master clock,
// serialises stereo pairs, and stays muted until PLL lock is qualified.
module audio_i2s_tx #(
    parameter int DATA_WIDTH = 24,
    parameter int BCLK_DIV   = 4,
    parameter int LOCK_WAIT  = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pll_locked,
    input  logic [DATA_WIDTH-1:0] in_left,
    input  logic [DATA_WIDTH-1:0] in_right,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  i2s_bclk,
    output logic                  i2s_lrclk,
    output logic                  i2s_sdata,
    output logic                  active,
    output logic                  underrun,
    output logic [15:0]           underrun_count
);

    localparam int LCW = $clog2(LOCK_WAIT + 1);
    localparam int DCW = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
    localparam int PAD = 32 - DATA_WIDTH;
    localparam logic [LCW-1:0] LOCK_END = LCW'(LOCK_WAIT);
    localparam logic [DCW-1:0] DIV_MAX  = DCW'(BCLK_DIV - 1);
    localparam logic [DCW-1:0] DIV_RISE = DCW'(BCLK_DIV / 2 - 1);

    typedef enum logic {
        WAIT_LOCK,
        RUN
    } state_t;

    state_t state_q, state_d;

    logic                  sync1, sync2;
    logic [LCW-1:0]        lock_cnt;
    logic [DCW-1:0]        div_cnt;
    logic [5:0]            bit_idx;
    logic [63:0]           frame;
    logic                  hold_full;
    logic [DATA_WIDTH-1:0] hold_l, hold_r;
    logic                  bclk_q, lrclk_q, sdata_q, underrun_q;
    logic [15:0]           ur_cnt;

    logic       go, fall, rise, load, lock_lost, accept;
    logic [5:0] idx_next, prev_slot;
    logic [31:0] l32, r32;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= WAIT_LOCK;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        go        = 1'b0;
        fall      = 1'b0;
        rise      = 1'b0;
        lock_lost = 1'b0;
        unique case (state_q)
            WAIT_LOCK: begin
                if (lock_cnt == LOCK_END) begin
                    state_d = RUN;
                    go      = 1'b1;
                    fall    = 1'b1;
                end
            end
            RUN: begin
                if (!sync2) begin
                    state_d   = WAIT_LOCK;
                    lock_lost = 1'b1;
                end else begin
                    fall = (div_cnt == DIV_MAX);
                    rise = (div_cnt == DIV_RISE);
                end
            end
        endcase
        idx_next  = go ? 6'd0 : bit_idx + 6'd1;
        prev_slot = idx_next - 6'd1;
        load      = fall && (idx_next == 6'd0);
        l32       = 32'(hold_l) << PAD;
        r32       = 32'(hold_r) << PAD;
    end

    assign in_ready = (state_q == RUN) && !hold_full;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            lock_cnt   <= '0;
            div_cnt    <= '0;
            bit_idx    <= '0;
            frame      <= '0;
            hold_full  <= 1'b0;
            hold_l     <= '0;
            hold_r     <= '0;
            bclk_q     <= 1'b0;
            lrclk_q    <= 1'b0;
            sdata_q    <= 1'b0;
            underrun_q <= 1'b0;
            ur_cnt     <= '0;
        end else begin
            sync1      <= pll_locked;
            sync2      <= sync1;
            underrun_q <= 1'b0;
            if (state_q == WAIT_LOCK && !go && sync2) begin
                lock_cnt <= lock_cnt + LCW'(1);
            end else begin
                lock_cnt <= '0;
            end
            if (lock_lost) begin
                div_cnt   <= '0;
                bit_idx   <= '0;
                frame     <= '0;
                hold_full <= 1'b0;
                bclk_q    <= 1'b0;
                lrclk_q   <= 1'b0;
                sdata_q   <= 1'b0;
            end else if (state_q == RUN || go) begin
                div_cnt <= fall ? '0 : div_cnt + DCW'(1);
                if (rise) begin
                    bclk_q <= 1'b1;
                end
                if (fall) begin
                    bclk_q  <= 1'b0;
                    bit_idx <= idx_next;
                    lrclk_q <= idx_next[5];
                    // one-bit I2S delay: emit the slot before the new index
                    sdata_q <= frame[~prev_slot];
                end
                if (load) begin
                    if (hold_full) begin
                        frame     <= {l32, r32};
                        hold_full <= 1'b0;
                    end else begin
                        frame      <= '0;
                        underrun_q <= 1'b1;
                        if (ur_cnt != 16'hFFFF) begin
                            ur_cnt <= ur_cnt + 16'd1;
                        end
                    end
                end
                if (accept) begin
                    hold_full <= 1'b1;
                    hold_l    <= in_left;
                    hold_r    <= in_right;
                end
            end
        end
    end

    assign i2s_bclk       = bclk_q;
    assign i2s_lrclk      = lrclk_q;
    assign i2s_sdata      = sdata_q;
    assign active         = (state_q == RUN);
    assign underrun       = underrun_q;
    assign underrun_count = ur_cnt;

endmodule
